// File: rtl/mips_mem_responder.sv
// Unified instruction/data word memory for the multicycle MIPS datapath with a
// programmable wait-state count and ready/err handshake. Define MEM_ALIGN_CHK_EN to reject misaligned accesses.
module mips_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateType;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_REJECT} opType;

    logic [31:0] mem [DEPTH];

    stateType              state;
    logic [3:0]            waitCnt;
    opType                 latchedOp;
    logic [DEPTH_LOG2-1:0] latchedIdx;
    logic [31:0]           latchedWdata;

    logic                  request;
    opType                 reqOp;
    logic [DEPTH_LOG2-1:0] reqIdx;
    opType                 effOp;
    logic [DEPTH_LOG2-1:0] effIdx;
    logic [31:0]           effWdata;
    logic                  enterResp;
    logic                  memWe;
    logic                  unusedAddrBits;

    assign request        = mem_read | mem_write;
    assign reqIdx         = addr[DEPTH_LOG2+1:2];
    assign unusedAddrBits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        reqOp = mem_write ? OP_WRITE : OP_READ;
        if (mem_read && mem_write) begin
            reqOp = OP_REJECT;
        end
`ifdef MEM_ALIGN_CHK_EN
        if (addr[1:0] != 2'b00) begin
            reqOp = OP_REJECT;
        end
`endif
    end

    // With zero wait states the access completes on its accepting edge, so use live inputs.
    assign effOp     = (state == IDLE) ? reqOp  : latchedOp;
    assign effIdx    = (state == IDLE) ? reqIdx : latchedIdx;
    assign effWdata  = (state == IDLE) ? wdata  : latchedWdata;
    assign enterResp = ((state == IDLE) && request && (WAIT_STATES == 0)) ||
                       ((state == BUSY) && (waitCnt == 4'd0));
    assign memWe     = enterResp && (effOp == OP_WRITE) && !rst;

    // NOTE: the memory array is deliberately not reset; only control state and outputs are.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[effIdx] <= effWdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            waitCnt      <= 4'd0;
            latchedOp    <= OP_READ;
            latchedIdx   <= '0;
            latchedWdata <= 32'd0;
            rdata        <= 32'd0;
            ready        <= 1'b0;
            err          <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            if (enterResp) begin
                ready <= 1'b1;
                err   <= (effOp == OP_REJECT);
                if (effOp == OP_READ) begin
                    rdata <= mem[effIdx];
                end
            end
            case (state)
                IDLE: begin
                    if (request) begin
                        latchedOp    <= reqOp;
                        latchedIdx   <= reqIdx;
                        latchedWdata <= wdata;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state   <= BUSY;
                            waitCnt <= WAIT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (waitCnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench for mips_mem_responder: two instances (0 and 2 wait
// states) compared against a word-array reference model of the access rules.
module tb_mips_mem_responder;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        memRead  [2];
    logic        memWrite [2];
    logic [31:0] addrIn   [2];
    logic [31:0] wdataIn  [2];
    logic [31:0] rdataOut [2];
    logic        readyOut [2];
    logic        errOut   [2];

    int numChecked = 0;
    int numFailed  = 0;

    logic [31:0] refMem   [2][256];
    logic [31:0] refRdata [2];
    int          waitOf   [2] = '{0, 2};

`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    mips_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dutWs0 (
        .clk(clk), .rst(rst[0]), .mem_read(memRead[0]), .mem_write(memWrite[0]),
        .addr(addrIn[0]), .wdata(wdataIn[0]), .rdata(rdataOut[0]),
        .ready(readyOut[0]), .err(errOut[0])
    );

    mips_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dutWs2 (
        .clk(clk), .rst(rst[1]), .mem_read(memRead[1]), .mem_write(memWrite[1]),
        .addr(addrIn[1]), .wdata(wdataIn[1]), .rdata(rdataOut[1]),
        .ready(readyOut[1]), .err(errOut[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecked++;
        if (got !== exp) begin
            numFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete handshake on instance d, checked against the reference model.
    task automatic access(input int d, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd);
        int lat;
        bit got;
        bit expErr;
        int idx;
        expErr = (rd && wr) || (ALIGN_CHK && (a % 4 != 0));
        idx    = (a / 4) % 256;
        if (!expErr) begin
            if (wr) refMem[d][idx] = wd;
            else    refRdata[d]    = refMem[d][idx];
        end
        @(negedge clk);
        memRead[d]  = rd;
        memWrite[d] = wr;
        addrIn[d]   = a;
        wdataIn[d]  = wd;
        @(posedge clk);
        #1;
        addrIn[d]  = $urandom;
        wdataIn[d] = $urandom;
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            @(negedge clk);
            lat++;
            if (readyOut[d]) got = 1'b1;
        end
        check($sformatf("latency d%0d", d), lat, waitOf[d] + 1);
        check($sformatf("err d%0d a=%h", d, a), {31'd0, errOut[d]}, {31'd0, expErr});
        check($sformatf("rdata d%0d a=%h", d, a), rdataOut[d], refRdata[d]);
        memRead[d]  = 1'b0;
        memWrite[d] = 1'b0;
        @(negedge clk);
        check($sformatf("ready pulse end d%0d", d), {31'd0, readyOut[d]}, 32'd0);
    endtask

    initial begin
        logic [31:0] oldVal;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; memRead[d] = 1'b0; memWrite[d] = 1'b0;
            addrIn[d] = 32'd0; wdataIn[d] = 32'd0; refRdata[d] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset ready", {31'd0, readyOut[d]}, 32'd0);
            check("reset err", {31'd0, errOut[d]}, 32'd0);
            check("reset rdata", rdataOut[d], 32'd0);
            rst[d] = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("idle ready", {31'd0, readyOut[d]}, 32'd0);
                check("idle rdata", rdataOut[d], 32'd0);
            end
        end

        // Preload every word so later reads are fully defined.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                access(d, 1'b0, 1'b1, i * 4, $urandom | 32'd1);

        // Directed: write/read round trip, wrap alias, simultaneous read+write.
        access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0);
        check("deadbeef readback", rdataOut[1], 32'hDEADBEEF);
        for (int d = 0; d < 2; d++) begin
            access(d, 1'b0, 1'b1, 32'h400, 32'h12345678);
            access(d, 1'b1, 1'b0, 32'h000, 32'h0);
            check("wrap alias", rdataOut[d], 32'h12345678);
            access(d, 1'b1, 1'b1, 32'h20, 32'hFFFF0000);
            access(d, 1'b1, 1'b0, 32'h20, 32'h0);
            access(d, 1'b1, 1'b0, 32'h22, 32'h0);
        end

        // Zero wait states with read held high: a new access every other cycle.
        @(negedge clk);
        memRead[0] = 1'b1;
        addrIn[0]  = 32'h40;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("held ready cyc%0d", i), {31'd0, readyOut[0]}, {31'd0, i % 2 == 1});
            if (i % 2 == 1) begin
                check($sformatf("held rdata cyc%0d", i), rdataOut[0], refMem[0][(addrIn[0] / 4) % 256]);
                refRdata[0] = refMem[0][(addrIn[0] / 4) % 256];
                addrIn[0]   = addrIn[0] + 32'd4;
            end
        end
        memRead[0] = 1'b0;

        // Reset during BUSY aborts the write.
        oldVal = refMem[1][12];
        access(1, 1'b1, 1'b0, 32'h34, 32'h0);
        @(negedge clk);
        memWrite[1] = 1'b1;
        addrIn[1]   = 32'h30;
        wdataIn[1]  = 32'hAAAA5555;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        check("abort ready", {31'd0, readyOut[1]}, 32'd0);
        check("abort err", {31'd0, errOut[1]}, 32'd0);
        check("abort rdata", rdataOut[1], 32'd0);
        memWrite[1] = 1'b0;
        refRdata[1] = 32'd0;
        @(negedge clk);
        rst[1] = 1'b0;
        access(1, 1'b1, 1'b0, 32'h30, 32'h0);
        check("abort old contents", rdataOut[1], oldVal);

        // Randomized mix of reads, writes, rejects, misaligned and aliased addresses.
        for (int n = 0; n < 120; n++) begin
            int d;
            int r;
            logic [31:0] a;
            d = n % 2;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 32'h3FFF);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            access(d, r < 4 || r >= 8, r >= 4, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecked, numFailed);
        $finish;
    end

endmodule
